// File: rtl/ulight_fifo_tpg_pkg.sv
// Shared types and constants for the ulight FIFO test-pattern generator:
// FSM encoding, control-word bit map, pattern codes/seeds and pattern stepping.
package ulight_fifo_tpg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_EOP  = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } tpg_state_e;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_PAT_LO = 1;
    localparam int CTRL_PAT_HI = 2;
    localparam int CTRL_SS     = 3;
    localparam int CTRL_CLEAR  = 4;

    localparam logic [1:0] PAT_INC  = 2'b00;
    localparam logic [1:0] PAT_WALK = 2'b01;
    localparam logic [1:0] PAT_LFSR = 2'b10;
    localparam logic [1:0] PAT_ALT  = 2'b11;

    localparam logic [7:0] SEED_INC  = 8'h00;
    localparam logic [7:0] SEED_WALK = 8'h01;
    localparam logic [7:0] SEED_LFSR = 8'h01;
    localparam logic [7:0] SEED_ALT  = 8'hA5;

    localparam int EOP_BIT = 8;

    function automatic logic [7:0] pat_seed(input logic [1:0] sel);
        logic [7:0] seed;
        case (sel)
            PAT_INC:  seed = SEED_INC;
            PAT_WALK: seed = SEED_WALK;
            PAT_LFSR: seed = SEED_LFSR;
            default:  seed = SEED_ALT;
        endcase
        return seed;
    endfunction

    // LFSR taps implement x^8+x^6+x^5+x^4+1 in a left-shifting register.
    function automatic logic [7:0] pat_next(input logic [1:0] sel, input logic [7:0] cur);
        logic [7:0] nxt;
        case (sel)
            PAT_INC:  nxt = cur + 8'd1;
            PAT_WALK: nxt = {cur[6:0], cur[7]};
            PAT_LFSR: nxt = {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
            default:  nxt = ~cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ulight_fifo_tpg_pattern.sv
// 8-bit payload generator: load restarts at the selected seed, advance steps one byte.
module ulight_fifo_tpg_pattern
    import ulight_fifo_tpg_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sel,
    input  logic       load,
    input  logic       advance,
    output logic [7:0] pat
);

    logic [7:0] pat_q;
    logic [7:0] pat_d;

    always_comb begin
        pat_d = pat_q;
        if (load) begin
            pat_d = pat_seed(sel);
        end else if (advance) begin
            pat_d = pat_next(sel, pat_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q <= '0;
        end else begin
            pat_q <= pat_d;
        end
    end

    assign pat = pat_q;

endmodule

// File: rtl/ulight_fifo_test_pattern_gen.sv
// Turns the PIO control word into test packets (PKT_LEN payload bytes + EOP marker)
// written into the ulight TX FIFO, with start/stop, single-shot, pattern select and packet count.
module ulight_fifo_test_pattern_gen
    import ulight_fifo_tpg_pkg::*;
#(
    parameter int PKT_LEN    = 16,
    parameter int GAP_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ctrl_in,
    input  logic             fifo_full,
    output logic             fifo_wrreq,
    output logic [8:0]       fifo_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pkt_count,
    output tpg_state_e       dbg_state
);

    // Valid/ready: a byte transfers on every clock where fifo_wrreq=1 (i.e. in SEND/EOP
    // with fifo_full=0); fifo_data is stable whenever fifo_wrreq is low.

    logic [4:0]       ctrl_q;
    tpg_state_e       state_q;
    logic [1:0]       sel_q;
    logic             ss_q;
    logic [7:0]       byte_cnt_q;
    logic [15:0]      gap_cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic       in_pkt;
    logic       gap_last;
    logic       pkt_start;
    logic [1:0] pat_sel;
    logic       pat_adv;
    logic [7:0] pat;

    assign in_pkt     = (state_q == ST_SEND) || (state_q == ST_EOP);
    assign fifo_wrreq = in_pkt & ~fifo_full;
    assign gap_last   = (gap_cnt_q == 16'(GAP_CYCLES - 1));

    // Any entry into SEND latches a fresh pattern/single-shot choice and reseeds.
    always_comb begin
        pkt_start = 1'b0;
        case (state_q)
            ST_IDLE: pkt_start = ctrl_q[CTRL_RUN];
            ST_EOP:  pkt_start = (GAP_CYCLES == 0) && fifo_wrreq && !ss_q && ctrl_q[CTRL_RUN];
            ST_GAP:  pkt_start = gap_last && ctrl_q[CTRL_RUN];
            default: pkt_start = 1'b0;
        endcase
    end

    assign pat_sel = pkt_start ? ctrl_q[CTRL_PAT_HI:CTRL_PAT_LO] : sel_q;
    assign pat_adv = (state_q == ST_SEND) && fifo_wrreq;

    ulight_fifo_tpg_pattern u_pattern (
        .clk     (clk),
        .reset   (reset),
        .sel     (pat_sel),
        .load    (pkt_start),
        .advance (pat_adv),
        .pat     (pat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            ss_q       <= 1'b0;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (pkt_start) begin
                sel_q      <= ctrl_q[CTRL_PAT_HI:CTRL_PAT_LO];
                ss_q       <= ctrl_q[CTRL_SS];
                byte_cnt_q <= '0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (pkt_start) begin
                        state_q <= ST_SEND;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (fifo_wrreq) begin
                        byte_cnt_q <= byte_cnt_q + 8'd1;
                        if (byte_cnt_q == 8'(PKT_LEN - 1)) begin
                            state_q <= ST_EOP;
                        end
                    end
                end
                ST_EOP: begin
                    if (fifo_wrreq) begin
                        if (ss_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (ctrl_q[CTRL_RUN]) begin
                            if (GAP_CYCLES == 0) begin
                                state_q <= ST_SEND;
                            end else begin
                                state_q   <= ST_GAP;
                                gap_cnt_q <= '0;
                            end
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_last) begin
                        if (ctrl_q[CTRL_RUN]) begin
                            state_q <= ST_SEND;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 16'd1;
                    end
                end
                ST_DONE: begin
                    if (!ctrl_q[CTRL_RUN]) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Clear has priority over a same-cycle EOP increment; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (ctrl_q[CTRL_CLEAR]) begin
            cnt_d = '0;
        end else if ((state_q == ST_EOP) && fifo_wrreq && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        fifo_data = '0;
        if (state_q == ST_SEND) begin
            fifo_data = {1'b0, pat};
        end else if (state_q == ST_EOP) begin
            fifo_data[EOP_BIT] = 1'b1;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pkt_count = cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ulight_fifo_test_pattern_gen.sv
// Randomized self-checking bench for the FIFO test-pattern generator against a packet-level model.
module tb_ulight_fifo_test_pattern_gen;
    import ulight_fifo_tpg_pkg::*;

    localparam int PKT_LEN = 16;
    localparam int GAP     = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ctrl;
    logic       full;
    logic       wrreq;
    logic [8:0] data;
    logic       busy;
    logic       done;
    logic [15:0] pcnt;
    tpg_state_e st;

    logic [4:0] s_ctrl;
    logic       s_wrreq;
    logic [8:0] s_data;
    logic       s_busy;
    logic       s_done;
    logic [1:0] s_pcnt;
    tpg_state_e s_st;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_cnt = 0;
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    int         got_t[$];
    logic [8:0] s_got[$];
    int         s_t[$];

    always #5 clk = ~clk;

    ulight_fifo_test_pattern_gen #(.PKT_LEN(PKT_LEN), .GAP_CYCLES(GAP), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .ctrl_in(ctrl), .fifo_full(full), .fifo_wrreq(wrreq),
        .fifo_data(data), .busy(busy), .done(done), .pkt_count(pcnt), .dbg_state(st)
    );

    // Short packets, no gap and a 2-bit counter make saturation reachable quickly.
    ulight_fifo_test_pattern_gen #(.PKT_LEN(1), .GAP_CYCLES(0), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .ctrl_in(s_ctrl), .fifo_full(1'b0), .fifo_wrreq(s_wrreq),
        .fifo_data(s_data), .busy(s_busy), .done(s_done), .pkt_count(s_pcnt), .dbg_state(s_st)
    );

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!reset && wrreq) begin
            got_q.push_back(data);
            got_t.push_back(cyc);
        end
        if (!reset && s_wrreq) begin
            s_got.push_back(s_data);
            s_t.push_back(cyc);
        end
    end

    function automatic logic [7:0] model_byte(input logic [1:0] p, input int idx);
        logic [7:0] v;
        case (p)
            2'b00: v = 8'(idx);
            2'b01: v = 8'(1 << (idx % 8));
            2'b10: begin
                v = 8'h01;
                for (int i = 0; i < idx; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
            end
            default: v = (idx % 2 == 0) ? 8'hA5 : 8'h5A;
        endcase
        return v;
    endfunction

    task automatic build_packet(input logic [1:0] p);
        for (int i = 0; i < PKT_LEN; i++) exp_q.push_back({1'b0, model_byte(p, i)});
        exp_q.push_back(9'h100);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic run, input logic [1:0] p, input logic ss, input logic clr);
        ctrl = {clr, ss, p, run};
    endtask

    task automatic clear_obs();
        got_q.delete();
        got_t.delete();
        exp_q.delete();
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ctrl = '0;
        s_ctrl = '0;
        full = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (wrreq !== 1'b0) begin errors++; $display("FAIL reset_wrreq got %b want 0", wrreq); end
        checks++; if (data !== 9'h000) begin errors++; $display("FAIL reset_data got %h want 000", data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (pcnt !== 16'h0) begin errors++; $display("FAIL reset_pkt_count got %h want 0", pcnt); end
        checks++; if (st !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", st); end
        checks++; if (s_pcnt !== 2'b00) begin errors++; $display("FAIL reset_sat_count got %h want 0", s_pcnt); end
        tick();
        reset = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_single_shot();
        logic [1:0] order[4];
        logic [1:0] p;
        logic [1:0] t;
        int j;
        int c0;
        bit ok;
        for (int i = 0; i < 4; i++) order[i] = 2'(i);
        for (int i = 3; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int k = 0; k < 4; k++) begin
            p = order[k];
            clear_obs();
            build_packet(p);
            c0 = cyc;
            drive(1'b1, p, 1'b1, 1'b0);
            repeat (8) tick();
            // pattern and single-shot flipped mid-packet must not take effect
            drive(1'b1, ~p, 1'b0, 1'b0);
            wait_done(ok);
            checks++; if (!ok) begin errors++; $display("FAIL single_shot_timeout pat=%0d got done=%b want 1", p, done); end
            repeat (3) tick();
            @(negedge clk);
            exp_cnt++;
            if (k == 0) begin
                checks++;
                if (got_t.size() == 0 || got_t[0] - c0 != 3) begin
                    errors++; $display("FAIL start_latency got %0d want 3", (got_t.size() == 0) ? -1 : got_t[0] - c0);
                end
            end
            checks++;
            if (got_q.size() != exp_q.size()) begin
                errors++; $display("FAIL single_shot_len pat=%0d got %0d want %0d", p, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL single_shot_byte pat=%0d idx=%0d got %h want %h", p, i, got_q[i], exp_q[i]);
                end
            end
            checks++; if (wrreq !== 1'b0) begin errors++; $display("FAIL single_shot_wrreq_after got %b want 0", wrreq); end
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_shot_done got %b want 1", done); end
            checks++; if (pcnt !== 16'(exp_cnt)) begin errors++; $display("FAIL single_shot_count got %0d want %0d", pcnt, exp_cnt); end
            drive(1'b0, p, 1'b0, 1'b0);
            repeat (3) tick();
            @(negedge clk);
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_release got done=%b busy=%b want 0 0", done, busy); end
        end
    endtask

    task automatic test_stall();
        int n;
        bit ok;
        clear_obs();
        build_packet(2'b01);
        drive(1'b1, 2'b01, 1'b1, 1'b0);
        n = 0;
        for (int i = 0; i < 50 && n < 3; i++) begin
            @(negedge clk);
            if (wrreq) n++;
        end
        checks++; if (n != 3) begin errors++; $display("FAIL stall_start got %0d writes want 3", n); end
        tick();
        full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (wrreq !== 1'b0 || data !== {1'b0, model_byte(2'b01, 3)} || st !== ST_SEND) begin
                errors++; $display("FAIL stall_hold cyc=%0d got wrreq=%b data=%h state=%0d want 0 %h SEND", i, wrreq, data, st, {1'b0, model_byte(2'b01, 3)});
            end
        end
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            full = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            checks++;
            if (full && wrreq) begin errors++; $display("FAIL stall_random got wrreq=1 want 0 while full"); end
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        full = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL stall_timeout got done=%b want 1", done); end
        repeat (2) tick();
        exp_cnt++;
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL stall_len got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL stall_byte idx=%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        drive(1'b0, 2'b01, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_continuous();
        int thr;
        bit ok;
        clear_obs();
        for (int k = 0; k < 3; k++) build_packet(2'b11);
        thr = 2 * (PKT_LEN + 1) + $urandom_range(1, 10);
        drive(1'b1, 2'b11, 1'b0, 1'b0);
        for (int i = 0; i < 400 && got_q.size() < thr; i++) @(negedge clk);
        tick();
        drive(1'b0, 2'b11, 1'b0, 1'b0);
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL continuous_timeout got busy=%b want 0", busy); end
        repeat (2) tick();
        @(negedge clk);
        exp_cnt += 3;
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL continuous_len got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL continuous_byte idx=%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        for (int k = 1; k < 3; k++) begin
            int e;
            e = k * (PKT_LEN + 1);
            if (got_t.size() > e) begin
                checks++;
                if (got_t[e] - got_t[e - 1] != GAP + 1) begin
                    errors++; $display("FAIL continuous_gap pkt=%0d got %0d idle want %0d", k, got_t[e] - got_t[e - 1] - 1, GAP);
                end
            end
        end
        checks++; if (pcnt !== 16'(exp_cnt)) begin errors++; $display("FAIL continuous_count got %0d want %0d", pcnt, exp_cnt); end
        checks++; if (st !== ST_IDLE) begin errors++; $display("FAIL continuous_end_state got %0d want IDLE", st); end
    endtask

    task automatic test_clear();
        logic [1:0] p;
        bit ok;
        p = 2'($urandom_range(0, 3));
        clear_obs();
        build_packet(p);
        drive(1'b1, p, 1'b1, 1'b1);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL clear_timeout got done=%b want 1", done); end
        tick();
        @(negedge clk);
        checks++; if (pcnt !== 16'h0) begin errors++; $display("FAIL clear_wins got %0d want 0", pcnt); end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL clear_packet_len got %0d want %0d", got_q.size(), exp_q.size());
        end
        drive(1'b0, p, 1'b0, 1'b0);
        repeat (3) tick();
        @(negedge clk);
        exp_cnt = 0;
        checks++; if (pcnt !== 16'(exp_cnt)) begin errors++; $display("FAIL clear_after got %0d want %0d", pcnt, exp_cnt); end
    endtask

    task automatic test_saturation();
        logic [1:0] p;
        int thr;
        int eops;
        int bad_t;
        for (int i = 0; i < 4; i++) begin
            if (s_busy) break;
        end
        p = 2'($urandom_range(0, 3));
        s_got.delete();
        s_t.delete();
        thr = 12 + $urandom_range(0, 5);
        s_ctrl = {1'b0, 1'b0, p, 1'b1};
        for (int i = 0; i < 100 && s_got.size() < thr; i++) @(negedge clk);
        tick();
        s_ctrl = {1'b0, 1'b0, p, 1'b0};
        repeat (6) tick();
        @(negedge clk);
        eops = 0;
        bad_t = 0;
        for (int i = 0; i < s_got.size(); i++) begin
            checks++;
            if (s_got[i] !== ((i % 2 == 0) ? {1'b0, model_byte(p, 0)} : 9'h100)) begin
                errors++; $display("FAIL sat_stream idx=%0d got %h want %h", i, s_got[i], (i % 2 == 0) ? {1'b0, model_byte(p, 0)} : 9'h100);
            end
            if (s_got[i] === 9'h100) eops++;
            if (i > 0 && s_t[i] != s_t[i - 1] + 1) bad_t++;
        end
        checks++; if (s_got.size() % 2 != 0) begin errors++; $display("FAIL sat_truncated got %0d writes want even", s_got.size()); end
        checks++; if (bad_t != 0) begin errors++; $display("FAIL sat_back_to_back got %0d gaps want 0", bad_t); end
        checks++; if (eops < 4) begin errors++; $display("FAIL sat_eop_count got %0d want >=4", eops); end
        checks++; if (s_pcnt !== 2'((eops > 3) ? 3 : eops)) begin errors++; $display("FAIL sat_count got %0d want %0d", s_pcnt, (eops > 3) ? 3 : eops); end
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL sat_idle got busy=%b want 0", s_busy); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] p;
        int n;
        int target;
        bit ok;
        p = 2'($urandom_range(0, 3));
        target = $urandom_range(2, 10);
        drive(1'b1, p, 1'b1, 1'b0);
        n = 0;
        for (int i = 0; i < 100 && n < target; i++) begin
            @(negedge clk);
            if (wrreq) n++;
        end
        checks++; if (n != target) begin errors++; $display("FAIL reset_mid_start got %0d writes want %0d", n, target); end
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (wrreq !== 1'b0 || data !== 9'h000 || busy !== 1'b0 || done !== 1'b0 || pcnt !== 16'h0 || st !== ST_IDLE) begin
            errors++; $display("FAIL reset_mid_outputs got wrreq=%b data=%h busy=%b done=%b cnt=%0d state=%0d want all 0/IDLE", wrreq, data, busy, done, pcnt, st);
        end
        tick();
        reset = 1'b0;
        clear_obs();
        build_packet(p);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL reset_mid_timeout got done=%b want 1", done); end
        repeat (2) tick();
        exp_cnt = 1;
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL reset_mid_len got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL reset_mid_byte idx=%0d got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++; if (pcnt !== 16'(exp_cnt)) begin errors++; $display("FAIL reset_mid_count got %0d want %0d", pcnt, exp_cnt); end
        drive(1'b0, p, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_stall();
        test_continuous();
        test_clear();
        test_saturation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog got no finish want finish before 1000000 ns");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
